spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Bus-side SPI master that sits directly upstream of the SPI slave/RAM pair.
- Accepts 10-bit command words (2-bit opcode + 8-bit payload) over a valid/ready handshake and serialises each one onto SS_n/MOSI as one SPI frame.
- For read-data commands, it shifts 8 bits back in from MISO and returns them as a one-cycle response pulse.
- The SPI link runs on the system clock: MOSI changes after a posedge, and the slave samples it on the next posedge.

Parameters:
- MEM_WIDTH, 8, payload/response width (taken from shared_pkg).
- TURNAROUND, 2, idle cycles between the last command bit and the first sampled MISO bit on read-data frames (1..15).
- END_GAP, 1, minimum cycles SS_n is held high between frames (1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command word present.
- cmd_data  input  MEM_WIDTH+2  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- cmd_ready  output  1  master can accept a command.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid.
- rsp_data  output  MEM_WIDTH  byte received from MISO.
- busy  output  1  high whenever state is not IDLE.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - SS_n=1, MOSI=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, state=IDLE.
  - A partial frame is abandoned; no response is issued.
- Registered outputs only; no combinational path from cmd_valid or MISO to any output.
- States: IDLE, CMD, SHIFT, TURN, RECV, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch cmd_data into a 10-bit shift register and go to CMD.
  - cmd_ready drops on the next cycle.
- CMD (1 cycle):
  - SS_n=0, MOSI=cmd[9] (the read/write select bit the slave checks first).
  - Go to SHIFT.
- SHIFT (10 cycles):
  - SS_n=0, MOSI=cmd[9] down to cmd[0], MSB first; a 4-bit counter counts 9..0.
  - At the end: opcode 11 -> TURN; otherwise -> GAP.
- TURN (TURNAROUND cycles): SS_n=0, MOSI=0, MISO ignored.
- RECV (MEM_WIDTH cycles):
  - SS_n=0, MOSI=0.
  - Sample MISO each posedge into rx shift register, MSB first.
  - Then go to GAP.
- GAP (END_GAP cycles):
  - SS_n=1, MOSI=0.
  - If the frame was rd-data, rsp_data=received byte and rsp_valid=1 on the first GAP cycle only.
  - rsp_data holds its value until the next rd-data response.
  - Then go to IDLE.
- Frame lengths with accept at edge T:
  - SS_n is low for cycles T+1..T+11 (11 cycles) for opcodes 00/01/10.
  - SS_n is low for cycles T+1..T+21 for opcode 11 with default parameters.
  - rsp_valid is high at T+22.
- Back-to-back commands:
  - cmd_ready rises in IDLE after GAP, so the minimum spacing is 11+END_GAP+1 cycles for write frames.
  - cmd_valid held while busy is ignored; the same word is accepted when ready returns.
- No response backpressure: rsp_valid is a pulse, and the consumer must capture it.
- Opcode 10 (rd-addr) produces no response.
- Counters saturate and never wrap while in the same state; leaving a state reloads the counter.

Decomposition:
- shared_pkg gains:
  - master_state_e (IDLE_M, CMD_M, SHIFT_M, TURN_M, RECV_M, GAP_M).
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - MEM_WIDTH stays where it is.
- SPI_if gains master-side signals and a spi_master modport (clk, rst_n, cmd_*, rsp_*, busy, SS_n, MOSI, MISO).
- Natural sub-module: spi_bit_counter (load value, decrement enable, zero flag), instanced once per counting state group.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> SS_n=1, MOSI=0, cmd_ready=1, rsp_valid=0. Assert rst_n=0 at frame cycle 5 -> SS_n=1 in the same cycle, no rsp_valid afterwards.
- Write address: cmd_data=10'b00_0011_1010 -> SS_n low 11 cycles, MOSI sequence 0,0,0,0,0,1,1,1,0,1,0, then SS_n high, no rsp_valid.
- Write data then read address: 10'h1A5, then 10'h23A -> two frames; the second frame's first MOSI bit=1; SS_n high for exactly END_GAP=1 cycle before the second frame's cmd_ready returns.
- Read data: cmd_data=10'h300, slave model drives MISO=0xA5 MSB first from T+14 -> rsp_valid=1 at T+22, rsp_data=8'hA5, busy low at T+23.
- Busy hold-off: cmd_valid held high with 10'h155 during the read frame -> accepted only in the first IDLE cycle after GAP, exactly one frame sent.
- Parameter sweep: TURNAROUND=1, END_GAP=3 -> read-data rsp_valid at T+21, SS_n high for 3 cycles.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared types and constants for the SPI master controller
package spi_master_ctrl_pkg;

    localparam int MEM_WIDTH = 8;
    localparam int CNT_W     = 4;
    localparam int CMD_W     = MEM_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE_M,
        CMD_M,
        SHIFT_M,
        TURN_M,
        RECV_M,
        GAP_M
    } master_state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // A state lasting len cycles counts len-1 down to 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/spi_master_ctrl_bit_counter.sv
// rtl/spi_master_ctrl_bit_counter.sv - loadable down-counter that saturates at zero
module spi_master_ctrl_bit_counter
    import spi_master_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - serialises 10-bit command words onto SS_n/MOSI, collects read bytes from MISO
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int END_GAP    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [CMD_W-1:0]     cmd_data,
    output logic                 cmd_ready,
    output logic                 rsp_valid,
    output logic [MEM_WIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam logic [CNT_W-1:0] SHIFT_LOAD = cnt_load(CMD_W);
    localparam logic [CNT_W-1:0] TURN_LOAD  = cnt_load(TURNAROUND);
    localparam logic [CNT_W-1:0] RECV_LOAD  = cnt_load(MEM_WIDTH);
    localparam logic [CNT_W-1:0] GAP_LOAD   = cnt_load(END_GAP);

    master_state_e        state_q, state_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [MEM_WIDTH-2:0] rx_q, rx_d;
    logic                 rd_frame_q, rd_frame_d;
    logic [MEM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_n_q, ss_n_d;
    logic                 busy_q, busy_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic                 sh_load, sh_dec, sh_zero;
    logic                 wt_load, wt_dec, wt_zero;
    logic [CNT_W-1:0]     wt_val;

    // Command bit counter for SHIFT; a second counter times TURN, RECV and GAP.
    spi_master_ctrl_bit_counter u_shift_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .load_val (SHIFT_LOAD),
        .dec_en   (sh_dec),
        .zero     (sh_zero)
    );

    spi_master_ctrl_bit_counter u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wt_load),
        .load_val (wt_val),
        .dec_en   (wt_dec),
        .zero     (wt_zero)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        rd_frame_d  = rd_frame_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        mosi_d      = 1'b0;
        sh_load     = 1'b0;
        sh_dec      = 1'b0;
        wt_load     = 1'b0;
        wt_dec      = 1'b0;
        wt_val      = GAP_LOAD;

        case (state_q)
            IDLE_M: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d      = cmd_data;
                    rd_frame_d = (cmd_data[CMD_W-1:CMD_W-2] == OP_RD_DATA);
                    mosi_d     = cmd_data[CMD_W-1];
                    state_d    = CMD_M;
                end
            end
            CMD_M: begin
                // The select bit is sent once up front, then again as the word's MSB.
                mosi_d  = cmd_q[CMD_W-1];
                sh_load = 1'b1;
                state_d = SHIFT_M;
            end
            SHIFT_M: begin
                if (!sh_zero) begin
                    sh_dec = 1'b1;
                    cmd_d  = cmd_q << 1;
                    mosi_d = cmd_q[CMD_W-2];
                end else if (rd_frame_q) begin
                    wt_load = 1'b1;
                    wt_val  = TURN_LOAD;
                    state_d = TURN_M;
                end else begin
                    wt_load = 1'b1;
                    wt_val  = GAP_LOAD;
                    state_d = GAP_M;
                end
            end
            TURN_M: begin
                if (!wt_zero) begin
                    wt_dec = 1'b1;
                end else begin
                    wt_load = 1'b1;
                    wt_val  = RECV_LOAD;
                    state_d = RECV_M;
                end
            end
            RECV_M: begin
                rx_d = {rx_q[MEM_WIDTH-3:0], MISO};
                if (!wt_zero) begin
                    wt_dec = 1'b1;
                end else begin
                    rsp_data_d  = {rx_q, MISO};
                    rsp_valid_d = 1'b1;
                    wt_load     = 1'b1;
                    wt_val      = GAP_LOAD;
                    state_d     = GAP_M;
                end
            end
            GAP_M: begin
                if (!wt_zero) begin
                    wt_dec = 1'b1;
                end else begin
                    state_d = IDLE_M;
                end
            end
            default: begin
                state_d = IDLE_M;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ss_n_d      = !((state_d == CMD_M) || (state_d == SHIFT_M) ||
                        (state_d == TURN_M) || (state_d == RECV_M));
        busy_d      = (state_d != IDLE_M);
        cmd_ready_d = (state_d == IDLE_M);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_M;
            cmd_q       <= '0;
            rx_q        <= '0;
            rd_frame_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            mosi_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            rd_frame_q  <= rd_frame_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            mosi_q      <= mosi_d;
            ss_n_q      <= ss_n_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

    localparam int NCYC = 1024;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
    logic [1:0][9:0] cmd_data;
    logic [1:0][7:0] rsp_data;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    spi_master_ctrl #(.TURNAROUND(2), .END_GAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]),
        .cmd_ready(cmd_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_ctrl #(.TURNAROUND(1), .END_GAP(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]),
        .cmd_ready(cmd_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Expected waveforms per instance and cycle, plus the observed log.
    bit e_ss [2][NCYC];
    bit e_mosi [2][NCYC];
    bit e_rdy [2][NCYC];
    bit e_busy [2][NCYC];
    bit e_rv [2][NCYC];
    logic [7:0] e_rbyte [2][NCYC];
    bit m_miso [2][NCYC];
    bit o_ss [2][NCYC];
    bit o_mosi [2][NCYC];
    bit o_rdy [2][NCYC];
    bit o_busy [2][NCYC];
    bit o_rv [2][NCYC];
    logic [7:0] o_rd [2][NCYC];
    int free_at [2];
    logic [7:0] hold [2];
    logic [7:0] rd_byte [2];

    function automatic int ta_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int eg_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void clear_from(input int i, input int c);
        for (int n = c; n < NCYC; n++) begin
            e_ss[i][n] = 1'b1;
            e_mosi[i][n] = 1'b0;
            e_rdy[i][n] = 1'b1;
            e_busy[i][n] = 1'b0;
            e_rv[i][n] = 1'b0;
            e_rbyte[i][n] = 8'h00;
            m_miso[i][n] = 1'b0;
        end
    endfunction

    // Frame accepted at the edge closing cycle t occupies cycles t+1 onward.
    function automatic void schedule(input int i, input int t, input logic [9:0] w);
        int len;
        bit rd;
        rd = (w[9:8] == 2'b11);
        len = rd ? (11 + ta_of(i) + 8) : 11;
        for (int n = t + 1; n <= t + len + eg_of(i); n++) begin
            e_rdy[i][n] = 1'b0;
            e_busy[i][n] = 1'b1;
            if (n <= t + len) e_ss[i][n] = 1'b0;
        end
        e_mosi[i][t + 1] = w[9];
        for (int k = 1; k <= 10; k++) e_mosi[i][t + 1 + k] = w[10 - k];
        if (rd) begin
            for (int j = 0; j < 8; j++) m_miso[i][t + 12 + ta_of(i) + j] = rd_byte[i][7 - j];
            e_rv[i][t + len + 1] = 1'b1;
            e_rbyte[i][t + len + 1] = rd_byte[i];
        end
        free_at[i] = t + len + eg_of(i) + 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", name, i, cyc, got, exp);
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++)
            if (rst_n && cmd_valid[i] && cyc >= free_at[i]) schedule(i, cyc, cmd_data[i]);
        @(negedge clk);
        if (cyc > NCYC - 64) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 64);
            $fatal(1);
        end
        for (int i = 0; i < 2; i++) begin
            if (e_rv[i][cyc]) hold[i] = e_rbyte[i][cyc];
            o_ss[i][cyc] = ss_n[i];
            o_mosi[i][cyc] = mosi[i];
            o_rdy[i][cyc] = cmd_ready[i];
            o_busy[i][cyc] = busy[i];
            o_rv[i][cyc] = rsp_valid[i];
            o_rd[i][cyc] = rsp_data[i];
            chk("ss_n", i, ss_n[i], e_ss[i][cyc]);
            chk("mosi", i, mosi[i], e_mosi[i][cyc]);
            chk("cmd_ready", i, cmd_ready[i], e_rdy[i][cyc]);
            chk("busy", i, busy[i], e_busy[i][cyc]);
            chk("rsp_valid", i, rsp_valid[i], e_rv[i][cyc]);
            chk("rsp_data", i, rsp_data[i], hold[i]);
            miso[i] = m_miso[i][cyc];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int cnt;
        logic [10:0] seq;

        rst_n = 1'b0;
        cmd_valid = '0;
        cmd_data = '0;
        miso = '0;
        for (int i = 0; i < 2; i++) begin
            clear_from(i, 0);
            free_at[i] = NCYC;
            hold[i] = 8'h00;
            rd_byte[i] = 8'h00;
        end

        repeat (3) step();
        chk("rst_ss_n", 0, ss_n, 2'b11);
        chk("rst_mosi", 0, mosi, 2'b00);
        chk("rst_ready", 0, cmd_ready, 2'b11);
        chk("rst_rsp_valid", 0, rsp_valid, 2'b00);
        chk("rst_busy", 0, busy, 2'b00);
        rst_n = 1'b1;
        free_at[0] = cyc;
        free_at[1] = cyc;
        repeat (2) step();

        // Write address 0x03A
        t = cyc;
        cmd_data[0] = 10'h03A;
        cmd_valid[0] = 1'b1;
        step();
        cmd_valid[0] = 1'b0;
        repeat (14) step();
        seq = '0;
        for (int k = 0; k < 11; k++) seq = {seq[9:0], o_mosi[0][t + 1 + k]};
        chk("wa_mosi_seq", 0, seq, 11'b00000111010);
        cnt = 0;
        for (int n = t + 1; n <= t + 12; n++) cnt += (o_ss[0][n] == 1'b0) ? 1 : 0;
        chk("wa_ss_low_cycles", 0, cnt, 11);
        chk("wa_ss_high_after", 0, o_ss[0][t + 12], 1);
        cnt = 0;
        for (int n = t + 1; n <= t + 14; n++) cnt += o_rv[0][n] ? 1 : 0;
        chk("wa_no_rsp", 0, cnt, 0);

        // Write data 0x1A5 then read address 0x23A, valid held
        t = cyc;
        cmd_data[0] = 10'h1A5;
        cmd_valid[0] = 1'b1;
        step();
        cmd_data[0] = 10'h23A;
        repeat (13) step();
        cmd_valid[0] = 1'b0;
        repeat (16) step();
        chk("b2b_ss_gap", 0, o_ss[0][t + 12], 1);
        chk("b2b_ready_gap", 0, o_rdy[0][t + 12], 0);
        chk("b2b_ready_back", 0, o_rdy[0][t + 13], 1);
        chk("b2b_second_ss", 0, o_ss[0][t + 14], 0);
        chk("b2b_second_first_bit", 0, o_mosi[0][t + 14], 1);

        // Read data 0x300 returning 0xA5, with 0x155 held during the frame
        t = cyc;
        rd_byte[0] = 8'hA5;
        cmd_data[0] = 10'h300;
        cmd_valid[0] = 1'b1;
        step();
        cmd_data[0] = 10'h155;
        repeat (23) step();
        cmd_valid[0] = 1'b0;
        repeat (16) step();
        chk("rd_no_early_rsp", 0, o_rv[0][t + 21], 0);
        chk("rd_rsp_valid", 0, o_rv[0][t + 22], 1);
        chk("rd_rsp_data", 0, o_rd[0][t + 22], 8'hA5);
        chk("rd_ss_last_low", 0, o_ss[0][t + 21], 0);
        chk("rd_busy_gap", 0, o_busy[0][t + 22], 1);
        chk("rd_busy_idle", 0, o_busy[0][t + 23], 0);
        chk("hold_ss_idle", 0, o_ss[0][t + 23], 1);
        chk("hold_next_frame", 0, o_ss[0][t + 24], 0);
        chk("hold_first_bit", 0, o_mosi[0][t + 24], 0);
        cnt = 0;
        for (int n = t + 1; n <= t + 40; n++) cnt += (o_ss[0][n] == 1'b0 && o_ss[0][n - 1] == 1'b1) ? 1 : 0;
        chk("hold_frame_count", 0, cnt, 2);
        chk("rsp_data_holds", 0, o_rd[0][t + 40], 8'hA5);

        // Reset in frame cycle 5
        t = cyc;
        cmd_data[0] = 10'h1A5;
        cmd_valid[0] = 1'b1;
        step();
        cmd_valid[0] = 1'b0;
        repeat (4) step();
        chk("pre_rst_ss_low", 0, ss_n[0], 0);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clear_from(i, cyc + 1);
            hold[i] = 8'h00;
            free_at[i] = NCYC;
        end
        #1;
        chk("mid_rst_ss_n", 0, ss_n[0], 1);
        chk("mid_rst_busy", 0, busy[0], 0);
        chk("mid_rst_ready", 0, cmd_ready[0], 1);
        repeat (2) step();
        rst_n = 1'b1;
        free_at[0] = cyc;
        free_at[1] = cyc;
        repeat (30) step();
        cnt = 0;
        for (int n = t + 1; n <= cyc; n++) cnt += o_rv[0][n] ? 1 : 0;
        chk("mid_rst_no_rsp", 0, cnt, 0);
        chk("mid_rst_rsp_data", 0, o_rd[0][cyc], 8'h00);

        // TURNAROUND=1 / END_GAP=3 read, alongside an all-ones read on the default instance
        t = cyc;
        rd_byte[1] = 8'h3C;
        cmd_data[1] = 10'h3C3;
        cmd_valid[1] = 1'b1;
        rd_byte[0] = 8'h81;
        cmd_data[0] = 10'h3FF;
        cmd_valid[0] = 1'b1;
        step();
        cmd_valid = '0;
        repeat (28) step();
        chk("sw_no_early_rsp", 1, o_rv[1][t + 20], 0);
        chk("sw_rsp_valid", 1, o_rv[1][t + 21], 1);
        chk("sw_rsp_data", 1, o_rd[1][t + 21], 8'h3C);
        chk("sw_ss_last_low", 1, o_ss[1][t + 20], 0);
        cnt = 0;
        for (int n = t + 21; n <= t + 24; n++) cnt += o_ss[1][n] ? 1 : 0;
        chk("sw_ss_high_cycles", 1, cnt, 4);
        chk("sw_ready_gap_end", 1, o_rdy[1][t + 23], 0);
        chk("sw_ready_back", 1, o_rdy[1][t + 24], 1);
        chk("ones_rsp_data", 0, o_rd[0][t + 22], 8'h81);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
